// File: rtl/alu_request_arbiter.sv
// Round-robin arbiter that shares one handshake ALU among NUM_REQ requesters,
// returning each result on a backpressured response channel with a no-answer watchdog.
module alu_request_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 15,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0]   resp_valid,
  input  logic [NUM_REQ-1:0]   resp_ready,
  output logic [7:0]           resp_result,
  output logic                 resp_err,
  output logic                 alu_in_valid,
  input  logic                 alu_in_ready,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [2:0]           alu_op,
  input  logic                 alu_out_valid,
  input  logic [7:0]           alu_result,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [7:0]       TIMER_LAST = 8'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [7:0]         timer_q, timer_d;
  logic [3:0]         a_q, a_d;
  logic [3:0]         b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [7:0]         result_q, result_d;
  logic               err_q, err_d;

  logic               found_s;
  logic [IDX_W-1:0]   win_s;
  logic [IDX_W-1:0]   cand_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic [NUM_REQ-1:0] resp_valid_s;

  // Round-robin scan from rr_ptr; walking downward lets the closest valid requester overwrite the rest.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    cand_s  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s  = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      win_s   = req_valid[cand_s] ? cand_s : win_s;
      found_s = found_s | req_valid[cand_s];
    end
  end

  // Next-state, operand capture, watchdog and accept pulse.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    timer_d     = timer_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    result_d    = result_q;
    err_d       = err_q;
    req_ready_s = '0;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          req_ready_s = ONE_HOT0 << win_s;
          owner_d     = win_s;
          a_d         = req_a[4*int'(win_s) +: 4];
          b_d         = req_b[4*int'(win_s) +: 4];
          op_d        = req_op[3*int'(win_s) +: 3];
          state_d     = S_ISSUE;
        end else begin
          state_d     = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (alu_in_ready) begin
          timer_d = 8'd0;
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        // A pulse arriving on the last allowed cycle still counts as a real answer.
        if (alu_out_valid) begin
          result_d = alu_result;
          err_d    = 1'b0;
          state_d  = S_RESP;
        end else if (timer_q == TIMER_LAST) begin
          result_d = 8'h00;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end else begin
          timer_d  = timer_q + 8'd1;
        end
      end
      S_RESP: begin
        if (resp_ready[owner_q]) begin
          state_d  = S_IDLE;
          rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
        end else begin
          state_d  = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      timer_q  <= 8'd0;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      op_q     <= 3'd0;
      result_q <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      timer_q  <= timer_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Response strobe decoded from state and owner.
  always_comb begin
    if (state_q == S_RESP) begin
      resp_valid_s = ONE_HOT0 << owner_q;
    end else begin
      resp_valid_s = '0;
    end
  end

  // Accept pulse is combinational, so it is held low while reset is asserted.
  assign req_ready    = rst_n ? req_ready_s : '0;
  assign resp_valid   = resp_valid_s;
  assign resp_result  = result_q;
  assign resp_err     = err_q;
  assign alu_in_valid = (state_q == S_ISSUE);
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_op       = op_q;
  assign grant_id     = owner_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Directed and randomized bench for alu_request_arbiter with a behavioural ALU and a
// transaction-level round-robin reference model.
`timescale 1ns/1ps
module tb_alu_request_arbiter;
  localparam int N   = 4;
  localparam int TMO = 15;
  localparam int IW  = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [4*N-1:0] req_a, req_b;
  logic [3*N-1:0] req_op;
  logic [7:0]     resp_result;
  logic           resp_err;
  logic           alu_in_valid, alu_in_ready;
  logic [3:0]     alu_a, alu_b;
  logic [2:0]     alu_op;
  logic           alu_out_valid;
  logic [7:0]     alu_result;
  logic [IW-1:0]  grant_id;
  logic           busy;

  int vectors     = 0;
  int miscompares = 0;

  bit       pend_v  [N];
  logic [3:0] pend_a [N];
  logic [3:0] pend_b [N];
  logic [2:0] pend_op[N];
  int       rr_m = 0;

  bit       alu_mute   = 1'b0;
  bit       ready_rand = 1'b0;
  bit       stray_en   = 1'b0;
  int       alu_lat    = 1;
  bit       alu_busy   = 1'b0;
  int       alu_cnt    = 0;
  logic [7:0] alu_res_h = 8'h00;

  int who, lat, gid;
  int order [6] = '{0, 1, 2, 3, 0, 1};

  alu_request_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_err(resp_err),
    .alu_in_valid(alu_in_valid), .alu_in_ready(alu_in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out_valid(alu_out_valid), .alu_result(alu_result),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return {4'd0, a} + {4'd0, b};
      3'd1:    return {4'd0, a} - {4'd0, b};
      3'd2:    return {4'd0, a} * {4'd0, b};
      3'd3:    return {4'd0, a & b};
      3'd4:    return {4'd0, a | b};
      3'd5:    return {4'd0, a ^ b};
      3'd6:    return {a, b};
      default: return {b, a};
    endcase
  endfunction

  // Behavioural ALU: accepts on in_valid&in_ready, answers alu_lat cycles later with one pulse.
  initial begin
    alu_in_ready  = 1'b0;
    alu_out_valid = 1'b0;
    alu_result    = 8'h00;
    forever begin
      @(negedge clk);
      alu_out_valid = 1'b0;
      if (!rst_n) begin
        alu_busy     = 1'b0;
        alu_in_ready = 1'b0;
        alu_result   = 8'h00;
      end else if (alu_busy) begin
        alu_in_ready = 1'b0;
        if (alu_cnt > 1) begin
          alu_cnt--;
        end else begin
          alu_busy = 1'b0;
          if (!alu_mute) begin
            alu_out_valid = 1'b1;
            alu_result    = alu_res_h;
          end
        end
      end else begin
        alu_in_ready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (stray_en && !alu_mute && $urandom_range(0, 3) == 0) begin
          alu_out_valid = 1'b1;
          alu_result    = 8'($urandom);
        end
        if (alu_in_valid && alu_in_ready) begin
          alu_busy  = 1'b1;
          alu_cnt   = alu_lat;
          alu_res_h = alu_fn(alu_a, alu_b, alu_op);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    pend_v[i] = 1'b1; pend_a[i] = a; pend_b[i] = b; pend_op[i] = op;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 4'($urandom), 4'($urandom), 3'($urandom));
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = pend_v[i];
      req_a[4*i +: 4]    = pend_a[i];
      req_b[4*i +: 4]    = pend_b[i];
      req_op[3*i +: 3]   = pend_op[i];
    end
  endtask

  function automatic int model_winner();
    for (int k = 0; k < N; k++) begin
      if (pend_v[(rr_m + k) % N]) return (rr_m + k) % N;
    end
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  32'(req_ready),  32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_result"},     32'(resp_result), 32'd0);
    check({tag, "_err"},        32'(resp_err),    32'd0);
    check({tag, "_alu_in"},     32'({alu_in_valid, alu_a, alu_b, alu_op}), 32'd0);
    check({tag, "_grant_busy"}, 32'({grant_id, busy}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b1;
    rr_m = 0;
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
  endtask

  // One full transaction: grant check, wait for response, hold, consume.
  task automatic serve(input bit refill, input int hold, output int w, output int l, output int g);
    logic [N-1:0] oh;
    logic [7:0]   er;
    logic         ee;
    int           n;
    @(negedge clk);
    drive_reqs();
    #1;
    w  = model_winner();
    l  = 0;
    g  = -1;
    oh = '0;
    if (w >= 0) oh[w] = 1'b1;
    check("idle_busy", 32'(busy), 32'd0);
    check("grant", 32'(req_ready), 32'(oh));
    if (w < 0) return;
    er = alu_mute ? 8'h00 : alu_fn(pend_a[w], pend_b[w], pend_op[w]);
    ee = alu_mute;
    @(posedge clk);
    #1;
    pend_v[w] = refill;
    if (refill) rand_req(w);
    drive_reqs();
    n = 0;
    do begin
      @(negedge clk);
      n++;
      check("busy_inflight", 32'(busy), 32'd1);
      check("no_grant_inflight", 32'(req_ready), 32'd0);
    end while (resp_valid == '0 && n < 60);
    l = n - 1;
    g = int'(grant_id);
    check("resp_valid", 32'(resp_valid), 32'(oh));
    check("resp_result", 32'(resp_result), 32'(er));
    check("resp_err", 32'(resp_err), 32'(ee));
    check("grant_id", 32'(grant_id), 32'(w));
    for (int h = 0; h < hold; h++) begin
      resp_ready = 4'($urandom) & ~oh;
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'(oh));
      check("hold_result", 32'({resp_err, resp_result}), 32'({ee, er}));
      check("hold_no_grant", 32'(req_ready), 32'd0);
    end
    resp_ready = oh | (4'($urandom) & ~oh);
    @(posedge clk);
    #1;
    resp_ready = '0;
    req_valid  = '0;
    rr_m = (w + 1) % N;
    check("done_busy", 32'(busy), 32'd0);
    check("done_resp_valid", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0; resp_ready = '0;
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0; pend_a[i] = 4'd0; pend_b[i] = 4'd0; pend_op[i] = 3'd0;
    end
    #2 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;

    // 1: single ADD, fixed one-cycle ALU
    set_req(0, 4'd3, 4'd5, 3'd0);
    serve(1'b0, 0, who, lat, gid);
    check("t1_latency", 32'(lat), 32'd2);

    // 2: simultaneous req0/req2 after reset, then rr_ptr=3 makes req3 beat req0
    do_reset();
    rand_req(0); rand_req(2);
    serve(1'b0, 1, who, lat, gid);
    check("t2_first", 32'(gid), 32'd0);
    serve(1'b0, 0, who, lat, gid);
    check("t2_second", 32'(gid), 32'd2);
    rand_req(0); rand_req(3);
    serve(1'b0, 0, who, lat, gid);
    check("t2_rr3", 32'(gid), 32'd3);
    serve(1'b0, 0, who, lat, gid);
    check("t2_rr0", 32'(gid), 32'd0);

    // 3: all four held valid continuously
    do_reset();
    for (int i = 0; i < N; i++) rand_req(i);
    for (int k = 0; k < 6; k++) begin
      serve(1'b1, 0, who, lat, gid);
      check("t3_order", 32'(gid), 32'(order[k]));
    end
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;

    // 4: MUL with slower ALU
    alu_lat = 5;
    set_req(1, 4'd7, 4'd9, 3'd2);
    serve(1'b0, 2, who, lat, gid);
    check("t4_latency", 32'(lat), 32'd6);

    // 5: ALU never answers -> watchdog exactly TMO cycles after the issue handshake
    alu_mute = 1'b1;
    rand_req(3);
    serve(1'b0, 1, who, lat, gid);
    check("t5_timeout_latency", 32'(lat), 32'(TMO + 1));
    alu_mute = 1'b0;

    // 6: owner stalls 10 cycles while others request
    alu_lat = 2;
    rand_req(0); rand_req(2); rand_req(3);
    serve(1'b0, 10, who, lat, gid);
    serve(1'b0, 0, who, lat, gid);
    serve(1'b0, 0, who, lat, gid);

    // 7: reset asserted mid-WAIT with another request pending
    alu_mute = 1'b1;
    rand_req(1);
    @(negedge clk);
    drive_reqs();
    #1 check("t7_grant", 32'(req_ready), 32'(rr_m == 1 || model_winner() == 1 ? 4'b0010 : 4'b0000));
    @(posedge clk);
    #1 pend_v[1] = 1'b0;
    rand_req(2);
    drive_reqs();
    repeat (5) @(negedge clk);
    check("t7_in_wait_busy", 32'({busy, alu_in_valid}), 32'b10);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("t7_midwait");
    @(negedge clk);
    req_valid = '0;
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    #3 rst_n = 1'b1;
    alu_mute = 1'b0;
    rr_m = 0;
    repeat (3) begin
      @(negedge clk);
      check("t7_idle_after", 32'({busy, resp_valid}), 32'd0);
    end

    // 8: randomized traffic with ready stalls, stray pulses and occasional timeouts
    ready_rand = 1'b1;
    stray_en   = 1'b1;
    for (int t = 0; t < 40; t++) begin
      alu_lat  = $urandom_range(1, 6);
      alu_mute = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && $urandom_range(0, 1) == 1) rand_req(i);
      end
      if (model_winner() < 0) rand_req($urandom_range(0, N - 1));
      serve(1'($urandom_range(0, 1)), $urandom_range(0, 3), who, lat, gid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
